// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: size codes, FSM states and the
// access legality check.
package mem_ctrl_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRd   = 2'd1,
        StWr   = 2'd2,
        StDone = 2'd3
    } state_e;

    // Request fields latched at acceptance so a pipeline flush cannot corrupt
    // an access already in flight.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [31:0] wdata;
    } req_t;

    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_B:  return 3'd1;
            SIZE_H:  return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Misaligned, illegal size, or any byte past the end of memory.
    function automatic logic access_err(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int unsigned mem_bytes);
        logic [32:0] end_addr;
        logic        bad;
        end_addr = {1'b0, addr} + {30'd0, size_bytes(size)};
        case (size)
            SIZE_X:  bad = 1'b1;
            SIZE_H:  bad = addr[0];
            SIZE_W:  bad = |addr[1:0];
            default: bad = 1'b0;
        endcase
        return bad || (end_addr > {1'b0, mem_bytes});
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake with the MEM stage plus the data-memory port.
interface mem_access_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall_o;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        err_o;
    logic        mem_ce;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    // Pipeline side plus memory model: drives requests and read data.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        input  stall_o, resp_valid, resp_rdata, err_o, mem_ce, mem_we, mem_addr, mem_wdata
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, mem_rdata,
        output stall_o, resp_valid, resp_rdata, err_o, mem_ce, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane handling: extracts/extends load data from a memory word and
// merges sub-word store data into a word for read-modify-write.
module mem_lane_align
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  offset_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);

    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] mask;

    assign shamt = {offset_i, 3'b000};

    // Load path: shift the addressed lane down, then extend.
    always_comb begin
        shifted = word_i >> shamt;
        case (size_i)
            SIZE_B:  load_o = {{24{signed_i & shifted[7]}}, shifted[7:0]};
            SIZE_H:  load_o = {{16{signed_i & shifted[15]}}, shifted[15:0]};
            default: load_o = word_i;
        endcase
    end

    // Store path: replace only the addressed lanes of the old word.
    always_comb begin
        case (size_i)
            SIZE_B:  mask = 32'h0000_00ff;
            SIZE_H:  mask = 32'h0000_ffff;
            default: mask = 32'hffff_ffff;
        endcase
        merge_o = (word_i & ~(mask << shamt)) | ((wdata_i & mask) << shamt);
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the MEM stage and a byte-addressed data memory.
// Sub-word stores go through a read-modify-write of the aligned word.
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_ctrl_if.slave bus
);

    state_e      state_q, state_d;
    req_t        req_q, req_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        err_q, err_d;
    logic        mem_ce_q, mem_ce_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] load_data;
    logic [31:0] merge_data;

    mem_lane_align u_align (
        .word_i   (bus.mem_rdata),
        .wdata_i  (req_q.wdata),
        .offset_i (req_q.off),
        .size_i   (req_q.size),
        .signed_i (req_q.sgn),
        .load_o   (load_data),
        .merge_o  (merge_data)
    );

    // Next state and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = '0;
        err_d        = 1'b0;
        mem_ce_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    req_d = '{we: bus.req_we, size: bus.req_size, sgn: bus.req_signed,
                              off: bus.req_addr[1:0], wdata: bus.req_wdata};
                    if (access_err(bus.req_size, bus.req_addr, MEM_BYTES)) begin
                        state_d      = StDone;
                        resp_valid_d = 1'b1;
                        err_d        = 1'b1;
                    end else begin
                        mem_addr_d = {bus.req_addr[31:2], 2'b00};
                        mem_ce_d   = 1'b1;
                        if (bus.req_we && bus.req_size == SIZE_W) begin
                            state_d     = StWr;
                            mem_we_d    = 1'b1;
                            mem_wdata_d = bus.req_wdata;
                        end else begin
                            state_d = StRd;
                        end
                    end
                end
            end
            StRd: begin
                if (req_q.we) begin
                    state_d     = StWr;
                    mem_ce_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_wdata_d = merge_data;
                end else begin
                    state_d      = StDone;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = load_data;
                end
            end
            StWr: begin
                state_d      = StDone;
                resp_valid_d = 1'b1;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            err_q        <= 1'b0;
            mem_ce_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            req_q        <= req_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            err_q        <= err_d;
            mem_ce_q     <= mem_ce_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Stall is released in DONE so the pipeline advances exactly once per access.
    assign bus.stall_o    = (state_q != StDone) && (bus.req_valid || state_q != StIdle);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.err_o      = err_q;
    assign bus.mem_ce     = mem_ce_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: expected responses are computed from a byte-array reference
// memory when a request is issued; a monitor compares them when resp_valid pulses.
module tb_mem_access_ctrl;

    localparam int unsigned MemBytes = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus ();

    mem_access_ctrl #(.MEM_BYTES(MemBytes)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
        int unsigned lat;
        bit          is_st;
        int unsigned waddr;
        logic [31:0] wword;
    } exp_t;

    logic [7:0]  mem     [MemBytes];
    logic [7:0]  ref_mem [MemBytes];
    exp_t        sb[$];
    int unsigned cyc = 0, wr_cnt = 0, ce_cnt = 0, viol = 0, exp_wr = 0, exp_ce = 0;
    logic [31:0] last_waddr = '0;
    int          n_cmp = 0, n_fail = 0;
    int unsigned ra;

    // Memory model: combinational read while ce && !we.
    always_comb begin
        ra            = {22'd0, bus.mem_addr[9:2], 2'b00};
        bus.mem_rdata = 32'h0;
        if (bus.mem_ce && !bus.mem_we)
            bus.mem_rdata = {mem[ra+3], mem[ra+2], mem[ra+1], mem[ra]};
    end

    // Memory write port plus cycle / enable bookkeeping.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.mem_ce) ce_cnt = ce_cnt + 1;
        if (bus.mem_we && !bus.mem_ce) viol = viol + 1;
        if (bus.mem_ce && bus.mem_we) begin
            wr_cnt     = wr_cnt + 1;
            last_waddr = bus.mem_addr;
            for (int i = 0; i < 4; i++)
                mem[int'({bus.mem_addr[9:2], 2'b00}) + i] = bus.mem_wdata[8*i +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pop the oldest expectation on each response.
    always @(negedge clk) begin
        if (rst_n && bus.resp_valid) begin
            exp_t e;
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got resp_valid=1 expected none queued");
            end else begin
                e = sb.pop_front();
                check("resp_rdata", bus.resp_rdata, e.rdata);
                check("err_o", {31'd0, bus.err_o}, {31'd0, e.err});
                check("latency", cyc - e.cyc, e.lat);
                if (e.is_st)
                    check("mem_word", {mem[e.waddr+3], mem[e.waddr+2], mem[e.waddr+1],
                                       mem[e.waddr]}, e.wword);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference model + driver for one request; returns in the IDLE cycle after DONE.
    task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata, input bit flush);
        exp_t        e;
        int unsigned nb;
        int unsigned a;
        bit          got;
        nb      = 1 << size;
        a       = addr;
        e.err   = (size == 2'b11) || (addr % nb != 0) || ({32'd0, addr} + nb > MemBytes);
        e.rdata = '0;
        e.is_st = 1'b0;
        e.waddr = 0;
        e.wword = '0;
        e.cyc   = cyc;
        if (e.err) begin
            e.lat = 1;
        end else if (we) begin
            for (int i = 0; i < int'(nb); i++) ref_mem[a+i] = wdata[8*i +: 8];
            e.is_st = 1'b1;
            e.waddr = a & ~32'd3;
            e.wword = {ref_mem[e.waddr+3], ref_mem[e.waddr+2], ref_mem[e.waddr+1],
                       ref_mem[e.waddr]};
            e.lat   = (nb == 4) ? 2 : 3;
            exp_wr++;
            exp_ce += (nb == 4) ? 1 : 2;
        end else begin
            for (int i = 0; i < int'(nb); i++) e.rdata[8*i +: 8] = ref_mem[a+i];
            if (sgn && nb == 1 && e.rdata[7])  e.rdata |= 32'hffff_ff00;
            if (sgn && nb == 2 && e.rdata[15]) e.rdata |= 32'hffff_0000;
            e.lat = 2;
            exp_ce++;
        end
        sb.push_back(e);

        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_valid  = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            if (bus.resp_valid) begin
                got = 1'b1;
                check("stall_in_done", {31'd0, bus.stall_o}, 32'd0);
            end else begin
                check("stall_busy", {31'd0, bus.stall_o}, 32'd1);
            end
            @(posedge clk);
            #1;
            if (flush) begin
                bus.req_valid = 1'b0;
                bus.req_addr  = $urandom;
                bus.req_wdata = $urandom;
                bus.req_size  = 2'($urandom);
                bus.req_we    = 1'($urandom);
            end
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 8 cycles");
        end
        bus.req_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned w_before;
        logic [1:0]  sz;
        logic [31:0] ad;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        for (int i = 0; i < int'(MemBytes); i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16'h10] = 8'h44; mem[16'h11] = 8'h33; mem[16'h12] = 8'h22; mem[16'h13] = 8'h11;
        for (int i = 16'h10; i < 16'h14; i++) ref_mem[i] = mem[i];

        rst_n = 1'b0;
        idle(2);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_err", {31'd0, bus.err_o}, 32'd0);
        check("rst_mem_ce", {31'd0, bus.mem_ce}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_stall", {31'd0, bus.stall_o}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // Directed: loads around 0x10.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 1'b0);
        mem[16'h12] = 8'h9a;
        ref_mem[16'h12] = 8'h9a;
        issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 1'b0);
        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0);
        mem[16'h12] = 8'h22;
        ref_mem[16'h12] = 8'h22;

        // Directed: byte store RMW.
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00ab, 1'b0);
        check("rmw_addr", last_waddr, 32'h10);

        // Directed: errors.
        issue(1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 1'b0);
        issue(1'b1, 2'b10, 1'b0, 32'h3fe, 32'hdead_beef, 1'b0);
        issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h3fc, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'hffff_fffc, 32'h0, 1'b0);
        idle(2);

        // Directed: reset while in RD of a byte store abandons it.
        w_before       = wr_cnt;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h11;
        bus.req_wdata  = 32'h55;
        bus.req_valid  = 1'b1;
        idle(1);
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        idle(1);
        exp_ce++;
        check("rstmid_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rstmid_mem_ce", {31'd0, bus.mem_ce}, 32'd0);
        check("rstmid_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("rstmid_mem_addr", bus.mem_addr, 32'd0);
        check("rstmid_mem_wdata", bus.mem_wdata, 32'd0);
        check("rstmid_rdata", bus.resp_rdata, 32'd0);
        rst_n = 1'b1;
        idle(3);
        check("rstmid_no_write", wr_cnt, w_before);
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0);
        issue(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 1'b0);

        // Directed: flush during RD of a load still completes.
        issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 1'b1);
        check("stall_after_flush", {31'd0, bus.stall_o}, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0:       ad = $urandom;
                1:       ad = 32'(MemBytes - 4 + $urandom_range(0, 3));
                2:       ad = $urandom_range(0, MemBytes - 1);
                default: ad = $urandom_range(0, MemBytes - 1) & ~32'(3 >> (2 - int'(sz[0])));
            endcase
            if (sz == 2'b10 && $urandom_range(0, 3) != 0) ad = ad & ~32'd3;
            issue(1'($urandom), sz, 1'($urandom), ad, $urandom, $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        idle(4);

        check("queue_drained", sb.size(), 32'd0);
        check("write_cycles", wr_cnt, exp_wr);
        check("ce_cycles", ce_cnt, exp_ce);
        check("we_without_ce", viol, 32'd0);
        begin
            int unsigned diffs;
            diffs = 0;
            for (int i = 0; i < int'(MemBytes); i++) if (mem[i] !== ref_mem[i]) diffs++;
            check("mem_final_diff", diffs, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
